// File: rtl/fb_rect_writer.sv
// fb_rect_writer
//   Writer side of the H_RES x V_RES framebuffer scanned out by the VGA read
//   path. Accepts one rectangle-fill or full-screen-clear command per
//   handshake, clips the rectangle to the screen, then writes one pixel per
//   clock in raster order using the read path's mapping addr = y*H_RES + x.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   iValid     command valid
//   oReady     command can be accepted this cycle (decoded from state)
//   iClear     1 = fill the whole screen, rectangle fields ignored
//   iX0, iY0   rectangle top-left corner
//   iW, iH     rectangle size in pixels
//   iColour    fill colour
//   oWrAddr    framebuffer write address (registered)
//   oWrData    framebuffer write data (registered)
//   oWrEn      framebuffer write strobe (registered)
//   oBusy      high in FILL and DONE (registered)
//   oDone      one-cycle pulse when a command completes (registered)
//   dbg_state  current FSM state, for observation only
//
// Handshake: a command is accepted on a rising edge where iValid && oReady.
// oReady is high only in IDLE; iValid seen in any other state is ignored and
// nothing is queued. All command fields are captured at the accept edge.
module fb_rect_writer #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic                   iClear,
  input  logic [7:0]             iX0,
  input  logic [6:0]             iY0,
  input  logic [7:0]             iW,
  input  logic [6:0]             iH,
  input  logic [COLOUR_BITS-1:0] iColour,
  output logic [14:0]            oWrAddr,
  output logic [COLOUR_BITS-1:0] oWrData,
  output logic                   oWrEn,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             x_q, x_d, xs_q, xs_d, xe_q, xe_d;
  logic [6:0]             y_q, y_d, ye_q, ye_d;
  logic [14:0]            addr_d;
  logic [COLOUR_BITS-1:0] data_d;
  logic                   wr_en_d, busy_d, done_d;

  logic [8:0]             sum_x;
  logic [7:0]             sum_y;
  logic [7:0]             clip_xe, nx;
  logic [6:0]             clip_ye, ny;
  logic                   degenerate;

  // y*160 + x as y*128 + y*32 + x: shift-add in 16 bits, then truncate.
  function automatic logic [14:0] addr_of(input logic [7:0] x, input logic [6:0] y);
    logic [15:0] a;
    a = {2'b00, y, 7'b0} + {4'b0000, y, 5'b0} + {8'b0, x};
    return a[14:0];
  endfunction

  // Clip: the end coordinate is min(start + size, limit) - 1. Sums are wide
  // enough that they never wrap.
  assign sum_x      = {1'b0, iX0} + {1'b0, iW};
  assign sum_y      = {1'b0, iY0} + {1'b0, iH};
  assign clip_xe    = (sum_x > 9'(H_RES)) ? 8'(H_RES - 1) : 8'(sum_x - 9'd1);
  assign clip_ye    = (sum_y > 8'(V_RES)) ? 7'(V_RES - 1) : 7'(sum_y - 8'd1);
  assign degenerate = !iClear && ((iW == 8'd0) || (iH == 7'd0) ||
                                  (iX0 >= 8'(H_RES)) || (iY0 >= 7'(V_RES)));

  assign oReady    = (state_q == S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    addr_d  = oWrAddr;
    data_d  = oWrData;
    wr_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    nx      = x_q;
    ny      = y_q;
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          data_d = iColour;
          busy_d = 1'b1;
          if (iClear) begin
            xs_d    = 8'd0;
            x_d     = 8'd0;
            y_d     = 7'd0;
            xe_d    = 8'(H_RES - 1);
            ye_d    = 7'(V_RES - 1);
            addr_d  = 15'd0;
            wr_en_d = 1'b1;
            state_d = S_FILL;
          end else if (degenerate) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            xs_d    = iX0;
            x_d     = iX0;
            y_d     = iY0;
            xe_d    = clip_xe;
            ye_d    = clip_ye;
            addr_d  = addr_of(iX0, iY0);
            wr_en_d = 1'b1;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        busy_d = 1'b1;
        if (x_q == xe_q && y_q == ye_q) begin
          // The last pixel was written this cycle.
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          if (x_q == xe_q) begin
            nx = xs_q;
            ny = y_q + 7'd1;
          end else begin
            nx = x_q + 8'd1;
            ny = y_q;
          end
          x_d     = nx;
          y_d     = ny;
          addr_d  = addr_of(nx, ny);
          wr_en_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      xs_q    <= 8'd0;
      xe_q    <= 8'd0;
      ye_q    <= 7'd0;
      oWrAddr <= 15'd0;
      oWrData <= '0;
      oWrEn   <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      oWrAddr <= addr_d;
      oWrData <= data_d;
      oWrEn   <= wr_en_d;
      oBusy   <= busy_d;
      oDone   <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;
  localparam int H  = 160;
  localparam int V  = 120;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          iValid;
  logic          oReady;
  logic          iClear;
  logic [7:0]    iX0;
  logic [6:0]    iY0;
  logic [7:0]    iW;
  logic [6:0]    iH;
  logic [CB-1:0] iColour;
  logic [14:0]   oWrAddr;
  logic [CB-1:0] oWrData;
  logic          oWrEn;
  logic          oBusy;
  logic          oDone;
  logic [1:0]    dbg_state;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [14:0]   exp_q[$];
  logic [CB-1:0] exp_colour;

  always #5 clk = ~clk;

  fb_rect_writer #(.H_RES(H), .V_RES(V), .COLOUR_BITS(CB)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .oReady(oReady),
    .iClear(iClear), .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH),
    .iColour(iColour), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oWrEn(oWrEn), .oBusy(oBusy), .oDone(oDone), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: enumerate the visible pixels of the command in raster
  // order and record their linear addresses.
  task automatic model_cmd(input bit clr, input int x0, input int y0,
                           input int w, input int h, input logic [CB-1:0] col);
    exp_q.delete();
    exp_colour = col;
    if (clr) begin
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          exp_q.push_back(15'(y * H + x));
    end else begin
      for (int y = y0; y < y0 + h && y < V; y++)
        for (int x = x0; x < x0 + w && x < H; x++)
          exp_q.push_back(15'(y * H + x));
    end
  endtask

  task automatic drive(input bit clr, input int x0, input int y0,
                       input int w, input int h, input logic [CB-1:0] col);
    iValid  = 1'b1;
    iClear  = clr;
    iX0     = 8'(x0);
    iY0     = 7'(y0);
    iW      = 8'(w);
    iH      = 7'(h);
    iColour = col;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (oReady !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'b0, oReady}, 32'd1);
  endtask

  // Entered 1 time unit after the accept edge; leaves 1 unit into the IDLE
  // cycle that follows the DONE pulse.
  task automatic expect_body(input string tag);
    logic [14:0] a;
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      chk({tag, "_wr_en"},   {31'b0, oWrEn},   32'd1);
      chk({tag, "_wr_addr"}, {17'b0, oWrAddr}, {17'b0, a});
      chk({tag, "_wr_data"}, {29'b0, oWrData}, {29'b0, exp_colour});
      chk({tag, "_ready_lo"}, {31'b0, oReady}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_done"},      {31'b0, oDone},  32'd1);
    chk({tag, "_done_wren"}, {31'b0, oWrEn},  32'd0);
    chk({tag, "_done_busy"}, {31'b0, oBusy},  32'd1);
    chk({tag, "_done_rdy"},  {31'b0, oReady}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_idle_rdy"},  {31'b0, oReady}, 32'd1);
    chk({tag, "_idle_done"}, {31'b0, oDone},  32'd0);
    chk({tag, "_idle_busy"}, {31'b0, oBusy},  32'd0);
    chk({tag, "_idle_wren"}, {31'b0, oWrEn},  32'd0);
  endtask

  task automatic run_cmd(input string tag, input bit clr, input int x0, input int y0,
                         input int w, input int h, input logic [CB-1:0] col);
    wait_ready();
    model_cmd(clr, x0, y0, w, h, col);
    drive(clr, x0, y0, w, h, col);
    @(posedge clk); #1;
    iValid = 1'b0;
    expect_body(tag);
  endtask

  initial begin
    int x0, y0, w, h;
    reset   = 1'b0;
    iValid  = 1'b0;
    iClear  = 1'b0;
    iX0     = '0;
    iY0     = '0;
    iW      = '0;
    iH      = '0;
    iColour = '0;

    // Clock/reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, oReady},  32'd1);
    chk("rst_wren",  {31'b0, oWrEn},   32'd0);
    chk("rst_done",  {31'b0, oDone},   32'd0);
    chk("rst_busy",  {31'b0, oBusy},   32'd0);
    chk("rst_addr",  {17'b0, oWrAddr}, 32'd0);
    chk("rst_data",  {29'b0, oWrData}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_cmd("rect",   1'b0, 10,  5,   2, 2, 3'd5);
    run_cmd("clip",   1'b0, 158, 118, 4, 4, 3'd3);
    run_cmd("deg_w0", 1'b0, 20,  20,  0, 3, 3'd1);
    run_cmd("deg_x",  1'b0, 160, 10,  5, 3, 3'd2);
    run_cmd("deg_h0", 1'b0, 5,   5,   4, 0, 3'd6);
    run_cmd("deg_y",  1'b0, 5,   120, 4, 2, 3'd7);
    run_cmd("clip_r", 1'b0, 150, 0,   255, 2, 3'd4);

    // Clear with garbage rectangle fields
    wait_ready();
    model_cmd(1'b1, 0, 0, 0, 0, 3'd0);
    drive(1'b1, 200, 127, 255, 127, 3'd0);
    @(posedge clk); #1;
    iValid = 1'b0;
    expect_body("clear");

    // Handshake: iValid held with new fields for the whole first command
    wait_ready();
    model_cmd(1'b0, 10, 5, 2, 2, 3'd5);
    drive(1'b0, 10, 5, 2, 2, 3'd5);
    @(posedge clk); #1;
    drive(1'b0, 40, 50, 3, 2, 3'd6);
    expect_body("hold1");
    model_cmd(1'b0, 40, 50, 3, 2, 3'd6);
    @(posedge clk); #1;
    iValid = 1'b0;
    expect_body("hold2");

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      x0 = $urandom_range(0, 170);
      y0 = $urandom_range(0, 127);
      case ($urandom_range(0, 3))
        0:       begin w = $urandom_range(0, 255); h = $urandom_range(0, 4);   end
        1:       begin w = $urandom_range(0, 4);   h = $urandom_range(0, 127); end
        default: begin w = $urandom_range(0, 12);  h = $urandom_range(0, 8);   end
      endcase
      run_cmd($sformatf("rnd%0d", i), 1'b0, x0, y0, w, h, 3'($urandom_range(0, 7)));
    end

    // Reset in the middle of a clear
    wait_ready();
    model_cmd(1'b1, 0, 0, 0, 0, 3'd2);
    drive(1'b1, 0, 0, 0, 0, 3'd2);
    @(posedge clk); #1;
    iValid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("abort_wr_addr", {17'b0, oWrAddr}, {17'b0, exp_q.pop_front()});
      @(posedge clk); #1;
    end
    #3;
    reset = 1'b0;
    #1;
    chk("abort_wren",  {31'b0, oWrEn},  32'd0);
    chk("abort_ready", {31'b0, oReady}, 32'd1);
    chk("abort_done",  {31'b0, oDone},  32'd0);
    chk("abort_busy",  {31'b0, oBusy},  32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_hold_done", {31'b0, oDone}, 32'd0);
      chk("abort_hold_wren", {31'b0, oWrEn}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", {31'b0, oDone}, 32'd0);
    run_cmd("one_px", 1'b0, 0, 0, 1, 1, 3'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Writer side of the 160x120, 3-bit colour framebuffer that the VGA read path scans out.
- Accepts one rectangle-fill or full-screen-clear command per handshake.
- Clips the rectangle to the screen, then writes one pixel per clock into the framebuffer RAM write port in raster order.
- Uses the same linear address mapping as the read path: addr = y*160 + x.

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in pixels.
- COLOUR_BITS, 3, colour word width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- iValid  input  1  command valid.
- oReady  output  1  block can accept a command this cycle.
- iClear  input  1  1 = full-screen fill, which ignores iX0, iY0, iW and iH.
- iX0  input  8  rectangle left x.
- iY0  input  7  rectangle top y.
- iW  input  8  rectangle width in pixels.
- iH  input  7  rectangle height in pixels.
- iColour  input  COLOUR_BITS  fill colour.
- oWrAddr  output  15  framebuffer write address.
- oWrData  output  COLOUR_BITS  framebuffer write data.
- oWrEn  output  1  framebuffer write strobe.
- oBusy  output  1  high in FILL and DONE states.
- oDone  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - oWrEn=0, oDone=0, oBusy=0, oReady=1, oWrAddr=0, oWrData=0.
  - All outputs are registered except oReady, which is decoded from state.
  - Asserting reset mid-fill aborts immediately: oWrEn drops without waiting for a clock, no oDone pulse is produced, and the command is lost.
- States: IDLE, FILL, DONE.
  - oReady=1 only in IDLE.
  - Accept condition: iValid && oReady at a rising edge.
  - iValid in FILL or DONE is ignored. There is no queueing.
- Command latch on accept:
  - All inputs are captured on accept. Later input changes have no effect.
  - For iClear=1: xs=0, ys=0, xe=H_RES-1, ye=V_RES-1.
  - Otherwise: xs=iX0, ys=iY0.
    - xe = min(iX0+iW, H_RES) - 1. The sum is computed at 9 bits, with no overflow.
    - ye = min(iY0+iH, V_RES) - 1. The sum is computed at 8 bits.
- Degenerate rectangles:
  - A command is degenerate if any of these holds: iClear=0 && (iW==0 || iH==0 || iX0>=H_RES || iY0>=V_RES).
  - Accept goes directly to DONE. No write is issued.
- Transitions:
  - IDLE -> FILL on a non-degenerate accept.
  - IDLE -> DONE on a degenerate accept.
  - FILL -> DONE after the write of (xe,ye).
  - DONE -> IDLE unconditionally after 1 cycle.
- Timing for an accept at edge N with P = (xe-xs+1)*(ye-ys+1) pixels:
  - Writes occur in cycles N+1 .. N+P, with oWrEn=1 continuously and no gaps.
  - oDone=1 only in cycle N+P+1, with oWrEn=0 in that cycle.
  - IDLE is reached at N+P+2; that is the earliest next accept edge.
  - For a degenerate command, oDone=1 at N+1 and IDLE is reached at N+2.
- Write sequence:
  - Raster order: x runs xs..xe, then wraps back to xs and y increments, until y reaches ye.
  - The cursor is (x,y).
  - oWrAddr = y*128 + y*32 + x, truncated to 15 bits; it is always < 19200.
  - oWrData = latched colour throughout the command.
- Address arithmetic:
  - Shift-add only, with no multiplier.
  - Use a 16-bit intermediate, then truncate to 15 bits.
- Invariant: oWrAddr never addresses a pixel outside the clipped rectangle.

Test Plan:
- Rect, iX0=10, iY0=5, iW=2, iH=2, iColour=5:
  - Exactly 4 writes on consecutive cycles starting 1 cycle after accept: addresses 810, 811, 970, 971, data 5 each.
  - oDone pulse the following cycle.
  - oReady high again one cycle after oDone.
- Clip, iX0=158, iY0=118, iW=4, iH=4, iColour=3:
  - Writes to 19038, 19039, 19198, 19199 only.
  - oDone after the 4th write. No address >= 19200 ever appears.
- Degenerate cases: iW=0; separately iX0=160 with iW=5:
  - Zero writes.
  - oDone exactly 1 cycle after accept; oReady back 2 cycles after accept.
- Clear, iClear=1, iColour=0, with iX0/iW set to garbage:
  - 19200 consecutive writes with addresses 0..19199 in order, data 0.
  - oDone at accept+19201.
- Handshake: hold iValid=1 with new fields during the fill of case 1:
  - No second command is started until IDLE.
  - The held command is accepted at the first IDLE edge, and its writes follow.
- Reset mid-clear: drive reset=0 asynchronously between clock edges after ~100 writes:
  - oWrEn drops to 0 before the next edge, oDone never pulses, oReady=1.
  - After release, a new 1x1 command at (0,0) writes only address 0.
